// File: rtl/axis_processor_if.sv
// Purpose: one stream link (tdata/tvalid/tready) shared by command input and fire-vector output.
// Latency: none, wiring only.
// Backpressure: a beat transfers on a rising clk edge where tvalid and tready are both high.
// Ports: W = tdata width; master drives tdata/tvalid, slave drives tready.
interface axis_processor_if #(
    parameter int W = 16
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_processor.sv
// Purpose: tiny spiking-neuron array driven by stream commands (NOP/RUN/AS/CLR/PERIODIC); RUN n emits n fire vectors.
// Latency: first fire vector valid 2 cycles after the RUN accept cycle, each later one 2 cycles after the previous handshake.
// Backpressure: commands accepted only in IDLE; output vector held stable until m_axis.tready.
// Ports: clk, arst (async, active-high), s_axis (slave, command packets), m_axis (master, one fire bit per neuron).
module axis_processor #(
    parameter int NUM_INP   = 2,
    parameter int INP_WIDTH = 16,
    parameter int OUT_WIDTH = NUM_INP,
    parameter int THRESHOLD = 1,
    parameter int CHARGE_W  = 8
) (
    input  logic             clk,
    input  logic             arst,
    axis_processor_if.slave  s_axis,
    axis_processor_if.master m_axis
);
    typedef enum logic [1:0] {IDLE, STEP, EMIT} state_t;

    localparam logic [2:0] OP_RUN = 3'b001;
    localparam logic [2:0] OP_AS  = 3'b010;
    localparam logic [2:0] OP_CLR = 3'b011;
    localparam logic [2:0] OP_PER = 3'b100;

    // Charge arithmetic runs two bits wider so charge + pending + periodic can never wrap before saturation.
    localparam logic [CHARGE_W+1:0] CMAX_X = {2'b00, {CHARGE_W{1'b1}}};
    localparam logic [CHARGE_W+1:0] THR_X  = THRESHOLD[CHARGE_W+1:0];

    state_t                state_q, state_d;
    logic [12:0]           remain_q, remain_d;
    logic                  rdy_q, rdy_d;
    logic                  vld_q, vld_d;
    logic [OUT_WIDTH-1:0]  tdata_q, tdata_d;

    logic [CHARGE_W-1:0]   charge_q [NUM_INP];
    logic [CHARGE_W-1:0]   charge_d [NUM_INP];
    logic [CHARGE_W-1:0]   pend_q   [NUM_INP];
    logic [CHARGE_W-1:0]   pend_d   [NUM_INP];
    logic [1:0]            pval_q   [NUM_INP];
    logic [1:0]            pval_d   [NUM_INP];
    logic [4:0]            pper_q   [NUM_INP];
    logic [4:0]            pper_d   [NUM_INP];
    logic [4:0]            pcnt_q   [NUM_INP];
    logic [4:0]            pcnt_d   [NUM_INP];

    // Command field decode.
    logic [INP_WIDTH-1:0]  cmd;
    logic [2:0]            cmd_op;
    logic                  cmd_ind;
    logic [1:0]            cmd_val;
    logic [4:0]            cmd_per;
    logic [12:0]           run_n;
    logic                  cmd_acc;
    logic                  unused_bits;

    assign cmd         = s_axis.tdata;
    assign cmd_op      = cmd[15:13];
    assign cmd_ind     = cmd[12];
    assign cmd_val     = cmd[11:10];
    assign cmd_per     = cmd[9:5];
    assign run_n       = cmd[12:0];
    assign unused_bits = ^cmd[4:0];
    assign cmd_acc     = s_axis.tvalid & rdy_q;

    // Per-neuron datapath: timestep sum/fire and AS pending accumulation.
    logic [NUM_INP-1:0]    sel;
    logic [NUM_INP-1:0]    due;
    logic [NUM_INP-1:0]    fire;
    logic [CHARGE_W+1:0]   step_sum [NUM_INP];
    logic [CHARGE_W+1:0]   step_sat [NUM_INP];
    logic [CHARGE_W:0]     as_sum   [NUM_INP];
    logic [CHARGE_W-1:0]   as_sat   [NUM_INP];

    for (genvar g = 0; g < NUM_INP; g++) begin : g_neuron
        // Only neurons 0 and 1 are addressable through the one-bit index field.
        assign sel[g]      = (g < 2) && (cmd_ind == 1'(g));
        assign due[g]      = (pper_q[g] != 5'd0) && (pcnt_q[g] == 5'd0);
        assign step_sum[g] = {2'b00, charge_q[g]} + {2'b00, pend_q[g]}
                           + (due[g] ? {{CHARGE_W{1'b0}}, pval_q[g]} : '0);
        assign step_sat[g] = (step_sum[g] > CMAX_X) ? CMAX_X : step_sum[g];
        assign fire[g]     = (step_sat[g] >= THR_X);
        assign as_sum[g]   = {1'b0, pend_q[g]} + {{(CHARGE_W-1){1'b0}}, cmd_val};
        assign as_sat[g]   = as_sum[g][CHARGE_W] ? {CHARGE_W{1'b1}} : as_sum[g][CHARGE_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        tdata_d  = tdata_q;
        charge_d = charge_q;
        pend_d   = pend_q;
        pval_d   = pval_q;
        pper_d   = pper_q;
        pcnt_d   = pcnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN: begin
                            if (run_n != 13'd0) begin
                                state_d  = STEP;
                                remain_d = run_n;
                            end
                        end
                        OP_AS: begin
                            for (int i = 0; i < NUM_INP; i++) begin
                                if (sel[i]) pend_d[i] = as_sat[i];
                            end
                        end
                        OP_CLR: begin
                            for (int i = 0; i < NUM_INP; i++) begin
                                charge_d[i] = '0;
                                pend_d[i]   = '0;
                                pval_d[i]   = '0;
                                pper_d[i]   = '0;
                                pcnt_d[i]   = '0;
                            end
                        end
                        OP_PER: begin
                            // Counter at 0 makes the new periodic input due on the very next timestep.
                            for (int i = 0; i < NUM_INP; i++) begin
                                if (sel[i]) begin
                                    pval_d[i] = cmd_val;
                                    pper_d[i] = cmd_per;
                                    pcnt_d[i] = '0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            STEP: begin
                for (int i = 0; i < NUM_INP; i++) begin
                    charge_d[i] = fire[i] ? '0 : step_sat[i][CHARGE_W-1:0];
                    pend_d[i]   = '0;
                    if (due[i]) begin
                        pcnt_d[i] = pper_q[i] - 5'd1;
                    end else if (pcnt_q[i] != 5'd0) begin
                        pcnt_d[i] = pcnt_q[i] - 5'd1;
                    end
                end
                tdata_d = OUT_WIDTH'(fire);
                state_d = EMIT;
            end
            EMIT: begin
                if (m_axis.tready) begin
                    remain_d = remain_q - 13'd1;
                    state_d  = (remain_q == 13'd1) ? IDLE : STEP;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so reset can hold them low.
        rdy_d = (state_d == IDLE);
        vld_d = (state_d == EMIT);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            tdata_q  <= '0;
            for (int i = 0; i < NUM_INP; i++) begin
                charge_q[i] <= '0;
                pend_q[i]   <= '0;
                pval_q[i]   <= '0;
                pper_q[i]   <= '0;
                pcnt_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            tdata_q  <= tdata_d;
            for (int i = 0; i < NUM_INP; i++) begin
                charge_q[i] <= charge_d[i];
                pend_q[i]   <= pend_d[i];
                pval_q[i]   <= pval_d[i];
                pper_q[i]   <= pper_d[i];
                pcnt_q[i]   <= pcnt_d[i];
            end
        end
    end

    assign s_axis.tready = rdy_q;
    assign m_axis.tvalid = vld_q;
    assign m_axis.tdata  = tdata_q;
endmodule

// File: tb/tb_axis_processor.sv
// Purpose: self-checking bench for axis_processor (THRESHOLD=1 main DUT, THRESHOLD=2 second DUT).
// Latency: checks 2-cycle accept-to-handshake spacing with downstream always ready.
// Backpressure: random and forced-low m_axis.tready; packets collected on the falling edge.
module tb_axis_processor;
    logic clk = 1'b0;
    logic arst;

    axis_processor_if #(.W(16)) s0 ();
    axis_processor_if #(.W(2))  m0 ();
    axis_processor_if #(.W(16)) s1 ();
    axis_processor_if #(.W(2))  m1 ();

    axis_processor #(.THRESHOLD(1)) dut  (.clk(clk), .arst(arst), .s_axis(s0), .m_axis(m0));
    axis_processor #(.THRESHOLD(2)) dut2 (.clk(clk), .arst(arst), .s_axis(s1), .m_axis(m1));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int bp_left = 0;
    int rnd_bp  = 0;
    int cmd_err = 0;

    logic [1:0] got0 [$];
    logic [1:0] got1 [$];
    int         hs0  [$];
    logic [1:0] exp_q [$];

    // ---------------- reference model (main DUT, threshold 1) ----------------
    localparam int CMAX = 255;
    localparam int MTHR = 1;
    int m_ch [2];
    int m_pd [2];
    int m_val[2];
    int m_per[2];
    int m_k  [2];   // timesteps elapsed since the PERIODIC command

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            m_ch[i] = 0; m_pd[i] = 0; m_val[i] = 0; m_per[i] = 0; m_k[i] = 0;
        end
    endfunction

    function automatic logic [1:0] model_step();
        logic [1:0] f;
        int add;
        f = 2'b00;
        for (int i = 0; i < 2; i++) begin
            add = m_pd[i];
            if (m_per[i] != 0) begin
                if ((m_k[i] % m_per[i]) == 0) add = add + m_val[i];
                m_k[i] = m_k[i] + 1;
            end
            m_ch[i] = m_ch[i] + add;
            if (m_ch[i] > CMAX) m_ch[i] = CMAX;
            if (m_ch[i] >= MTHR) begin
                f[i] = 1'b1;
                m_ch[i] = 0;
            end
            m_pd[i] = 0;
        end
        return f;
    endfunction

    function automatic void model_cmd(input logic [15:0] d);
        int ind;
        ind = int'(d[12]);
        case (d[15:13])
            3'b001: for (int j = 0; j < int'(d[12:0]); j++) exp_q.push_back(model_step());
            3'b010: begin
                m_pd[ind] = m_pd[ind] + int'(d[11:10]);
                if (m_pd[ind] > CMAX) m_pd[ind] = CMAX;
            end
            3'b011: model_clear();
            3'b100: begin
                m_val[ind] = int'(d[11:10]);
                m_per[ind] = int'(d[9:5]);
                m_k[ind]   = 0;
            end
            default: ;
        endcase
    endfunction

    // ---------------- command builders ----------------
    function automatic logic [15:0] f_run(input int n);
        return {3'b001, 13'(n)};
    endfunction
    function automatic logic [15:0] f_as(input int ind, input int val);
        return {3'b010, 1'(ind), 2'(val), 10'd0};
    endfunction
    function automatic logic [15:0] f_per(input int ind, input int val, input int per);
        return {3'b100, 1'(ind), 2'(val), 5'(per), 5'd0};
    endfunction
    function automatic logic [15:0] f_clr();
        return {3'b011, 13'd0};
    endfunction

    // ---------------- background processes ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bp_left > 0) begin
            m0.tready = 1'b0;
            bp_left = bp_left - 1;
        end else begin
            m0.tready = ($urandom_range(99) >= rnd_bp);
        end
    end

    // Handshake monitor: inputs only change just after the rising edge, so the falling edge sees what the next edge takes.
    always @(negedge clk) begin
        if (m0.tvalid === 1'b1 && m0.tready === 1'b1) begin
            got0.push_back(m0.tdata);
            hs0.push_back(cyc + 1);
        end
        if (m1.tvalid === 1'b1 && m1.tready === 1'b1) got1.push_back(m1.tdata);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input int sel, input logic [15:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (sel == 0) begin s0.tdata = d; s0.tvalid = 1'b1; end
        else          begin s1.tdata = d; s1.tvalid = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            if (((sel == 0) ? s0.tready : s1.tready) === 1'b1) begin
                if (sel == 0) begin
                    acc_cyc = cyc + 1;
                    model_cmd(d);
                end
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        s0.tvalid = 1'b0;
        s1.tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (((sel == 0) ? s0.tready : s1.tready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_cmd(input int sel, input logic [15:0] d);
        bit ok;
        send_cmd(sel, d, ok);
        if (!ok) cmd_err++;
        wait_idle(sel, ok);
        if (!ok) cmd_err++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (m0.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b expected 0", m0.tvalid); end
        total++; if (s0.tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b expected 0", s0.tready); end
        total++; if (m0.tdata !== 2'b00) begin bad++; $display("FAIL reset_tdata: got %b expected 00", m0.tdata); end
        arst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        total++; if (s0.tready !== 1'b1) begin bad++; $display("FAIL release_tready: got %b expected 1", s0.tready); end
        total++; if (m0.tvalid !== 1'b0) begin bad++; $display("FAIL release_tvalid: got %b expected 0", m0.tvalid); end
    endtask

    task automatic test_periodic_single();
        logic [6:0] pat;
        int a;
        pat = 7'b1001001;   // bit k = packet k
        cmd_err = 0;
        do_cmd(0, f_clr());
        do_cmd(0, f_per(0, 1, 3));
        got0.delete(); hs0.delete();
        do_cmd(0, f_run(7));
        a = acc_cyc;
        total++; if (cmd_err != 0) begin bad++; $display("FAIL periodic1_cmd: timeouts %0d expected 0", cmd_err); end
        total++; if (got0.size() != 7) begin bad++; $display("FAIL periodic1_count: got %0d expected 7", got0.size()); end
        for (int i = 0; i < 7 && i < got0.size(); i++) begin
            total++;
            if (got0[i] !== {1'b0, pat[i]}) begin
                bad++; $display("FAIL periodic1_pkt%0d: got %b expected %b", i, got0[i], {1'b0, pat[i]});
            end
            total++;
            if (hs0[i] - ((i == 0) ? a : hs0[i-1]) != 2) begin
                bad++; $display("FAIL latency_pkt%0d: got %0d cycles expected 2", i, hs0[i] - ((i == 0) ? a : hs0[i-1]));
            end
        end
    endtask

    task automatic test_periodic_two();
        logic [1:0] ev [6];
        ev = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
        cmd_err = 0;
        do_cmd(0, f_clr());
        do_cmd(0, f_per(0, 1, 3));
        do_cmd(0, f_per(1, 1, 2));
        got0.delete();
        do_cmd(0, f_run(6));
        total++; if (cmd_err != 0) begin bad++; $display("FAIL periodic2_cmd: timeouts %0d expected 0", cmd_err); end
        total++; if (got0.size() != 6) begin bad++; $display("FAIL periodic2_count: got %0d expected 6", got0.size()); end
        for (int i = 0; i < 6 && i < got0.size(); i++) begin
            total++;
            if (got0[i] !== ev[i]) begin bad++; $display("FAIL periodic2_pkt%0d: got %b expected %b", i, got0[i], ev[i]); end
        end
    endtask

    task automatic test_as_run0();
        int stuck;
        cmd_err = 0;
        do_cmd(0, f_clr());
        do_cmd(0, f_as(1, 1));
        got0.delete();
        do_cmd(0, f_run(2));
        total++; if (got0.size() != 2) begin bad++; $display("FAIL as_count: got %0d expected 2", got0.size()); end
        if (got0.size() == 2) begin
            total++; if (got0[0] !== 2'b10) begin bad++; $display("FAIL as_pkt0: got %b expected 10", got0[0]); end
            total++; if (got0[1] !== 2'b00) begin bad++; $display("FAIL as_pkt1: got %b expected 00", got0[1]); end
        end
        got0.delete();
        do_cmd(0, f_run(0));
        stuck = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s0.tready !== 1'b1 || m0.tvalid !== 1'b0) stuck++;
        end
        total++; if (stuck != 0) begin bad++; $display("FAIL run0_ready: got %0d cycles not idle expected 0", stuck); end
        total++; if (got0.size() != 0) begin bad++; $display("FAIL run0_packets: got %0d expected 0", got0.size()); end
        total++; if (cmd_err != 0) begin bad++; $display("FAIL as_cmd: timeouts %0d expected 0", cmd_err); end
    endtask

    task automatic test_threshold2();
        cmd_err = 0;
        got1.delete();
        do_cmd(1, f_as(0, 1));
        do_cmd(1, f_run(1));
        do_cmd(1, f_as(0, 1));
        do_cmd(1, f_run(1));
        total++; if (cmd_err != 0) begin bad++; $display("FAIL thr2_cmd: timeouts %0d expected 0", cmd_err); end
        total++; if (got1.size() != 2) begin bad++; $display("FAIL thr2_count: got %0d expected 2", got1.size()); end
        if (got1.size() == 2) begin
            total++; if (got1[0] !== 2'b00) begin bad++; $display("FAIL thr2_pkt0: got %b expected 00", got1[0]); end
            total++; if (got1[1] !== 2'b01) begin bad++; $display("FAIL thr2_pkt1: got %b expected 01", got1[1]); end
        end
    endtask

    task automatic test_backpressure_clr();
        bit ok;
        int held, bad_hold;
        cmd_err = 0;
        do_cmd(0, f_clr());
        do_cmd(0, f_per(0, 1, 1));
        got0.delete();
        @(negedge clk);
        bp_left = 8;
        send_cmd(0, f_run(3), ok);
        if (!ok) cmd_err++;
        held = 0; bad_hold = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m0.tvalid === 1'b1 && m0.tready === 1'b0) begin
                held++;
                if (m0.tdata !== 2'b01) bad_hold++;
            end
        end
        wait_idle(0, ok);
        if (!ok) cmd_err++;
        total++; if (held < 3) begin bad++; $display("FAIL bp_stall: got %0d stalled cycles expected at least 3", held); end
        total++; if (bad_hold != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad_hold); end
        total++; if (got0.size() != 3) begin bad++; $display("FAIL bp_count: got %0d expected 3", got0.size()); end
        for (int i = 0; i < 3 && i < got0.size(); i++) begin
            total++; if (got0[i] !== 2'b01) begin bad++; $display("FAIL bp_pkt%0d: got %b expected 01", i, got0[i]); end
        end
        do_cmd(0, f_clr());
        got0.delete();
        do_cmd(0, f_run(2));
        total++; if (got0.size() != 2) begin bad++; $display("FAIL clr_count: got %0d expected 2", got0.size()); end
        for (int i = 0; i < 2 && i < got0.size(); i++) begin
            total++; if (got0[i] !== 2'b00) begin bad++; $display("FAIL clr_pkt%0d: got %b expected 00", i, got0[i]); end
        end
        total++; if (cmd_err != 0) begin bad++; $display("FAIL bp_cmd: timeouts %0d expected 0", cmd_err); end
    endtask

    task automatic test_random();
        logic [15:0] d;
        int op;
        int diffs;
        cmd_err = 0;
        rnd_bp = 30;
        do_cmd(0, f_clr());
        got0.delete();
        exp_q.delete();
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(7);
            if (op == 1) d = {3'b001, 13'($urandom_range(5))};
            else         d = {3'(op), 13'($urandom)};
            do_cmd(0, d);
        end
        rnd_bp = 0;
        total++; if (got0.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d expected %0d", got0.size(), exp_q.size()); end
        diffs = 0;
        for (int i = 0; i < got0.size() && i < exp_q.size(); i++) begin
            total++;
            if (got0[i] !== exp_q[i]) begin
                bad++;
                if (diffs < 5) $display("FAIL rand_pkt%0d: got %b expected %b", i, got0[i], exp_q[i]);
                diffs++;
            end
        end
        total++; if (cmd_err != 0) begin bad++; $display("FAIL rand_cmd: timeouts %0d expected 0", cmd_err); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int seen;
        cmd_err = 0;
        do_cmd(0, f_clr());
        do_cmd(0, f_per(0, 1, 1));
        @(negedge clk);
        bp_left = 1000;
        send_cmd(0, f_run(50), ok);
        if (!ok) cmd_err++;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0.tvalid === 1'b1) begin seen = 1; break; end
        end
        total++; if (seen != 1) begin bad++; $display("FAIL midrun_valid: got %0d expected 1", seen); end
        #2;
        arst = 1'b1;
        #1;
        total++; if (m0.tvalid !== 1'b0) begin bad++; $display("FAIL midrun_rst_tvalid: got %b expected 0", m0.tvalid); end
        total++; if (s0.tready !== 1'b0) begin bad++; $display("FAIL midrun_rst_tready: got %b expected 0", s0.tready); end
        total++; if (m0.tdata !== 2'b00) begin bad++; $display("FAIL midrun_rst_tdata: got %b expected 00", m0.tdata); end
        @(negedge clk);
        arst = 1'b0;
        bp_left = 0;
        model_clear();
        exp_q.delete();
        got0.delete();
        @(posedge clk); #1;
        total++; if (s0.tready !== 1'b1) begin bad++; $display("FAIL midrun_release_tready: got %b expected 1", s0.tready); end
        do_cmd(0, f_run(1));
        total++; if (got0.size() != 1) begin bad++; $display("FAIL midrun_count: got %0d expected 1", got0.size()); end
        if (got0.size() == 1) begin
            total++; if (got0[0] !== 2'b00) begin bad++; $display("FAIL midrun_pkt: got %b expected 00", got0[0]); end
        end
        total++; if (cmd_err != 0) begin bad++; $display("FAIL midrun_cmd: timeouts %0d expected 0", cmd_err); end
    endtask

    initial begin
        arst      = 1'b1;
        s0.tdata  = '0; s0.tvalid = 1'b0;
        s1.tdata  = '0; s1.tvalid = 1'b0;
        m1.tready = 1'b1;
        m0.tready = 1'b1;
        model_clear();

        test_reset();
        test_periodic_single();
        test_periodic_two();
        test_as_run0();
        test_threshold2();
        test_backpressure_clr();
        test_random();
        test_reset_mid_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
